enc_btn_event_queue: RTL and testbench
======================================

# enc_btn_event_queue

Converts the debounced pushbutton and slide-switch levels from the PmodENC input conditioning stage into discrete, timestamp-free events (press, short/long release, long-hold, switch on/off) and queues them in a 4-entry FIFO. The queue is read by the peripheral's register interface through a valid/ack handshake. Overflow is flagged, never silently wrapped. It sits between the debouncer outputs and the AXI-facing register block.

## Interface
Parameters:
- CLOCK_FREQ_HZ, 100000000, input clock frequency.
- LONG_PRESS_MS, 1000, button hold time that qualifies as a long press.
- SIMULATE, 0, when nonzero the long-press threshold L is fixed at 10 cycles.
- Otherwise L = (CLOCK_FREQ_HZ/1000)*LONG_PRESS_MS, a 32-bit constant.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- BTN_in  in  1  debounced pushbutton level, synchronous to clk.
- SWT_in  in  1  debounced switch level, synchronous to clk.
- evt_ack  in  1  consumer pops the head entry.
- ovf_clr  in  1  clears the overflow flag.
- evt_valid  out  1  FIFO not empty.
- evt_code  out  3  head entry; 3'b000 when empty.
- fifo_count  out  3  occupancy, 0–4.
- overflow  out  1  sticky flag: an event was dropped.
- press_count  out  16  total PRESS events, wraps 16'hFFFF→0.
- btn_state  out  2  FSM state: 0 IDLE, 1 PRESSED, 2 HELD.

## Operation
- Event codes:
  - 1 PRESS
  - 2 RELEASE_SHORT
  - 3 RELEASE_LONG
  - 4 LONG_HOLD
  - 5 SWT_ON
  - 6 SWT_OFF
  - 0 and 7 are unused.
- Edge detection uses registers btn_prev and swt_prev, both reset to 0. A level already high when reset is released therefore produces PRESS / SWT_ON on the first clock.
- Button FSM with 32-bit hold counter hcnt:
  - IDLE: on a BTN_in rising edge → PRESSED, set hcnt=0, push PRESS, increment press_count.
  - PRESSED, BTN_in low: → IDLE, push RELEASE_SHORT.
  - PRESSED, BTN_in high and hcnt==L-1: → HELD, push LONG_HOLD.
  - PRESSED, otherwise: hcnt+1.
  - HELD, BTN_in low: → IDLE, push RELEASE_LONG. hcnt is frozen while in HELD.
- Switch: a rising edge on SWT_in pushes SWT_ON; a falling edge pushes SWT_OFF. The switch has no FSM.
- Each cycle generates at most 2 push requests. The button event occupies the first slot and the switch event the second, so order in the FIFO is always button before switch.
- FIFO is 4 entries × 3 bits, with circular read/write pointers.
- Pop: evt_ack while evt_valid removes the head. evt_ack while empty is ignored.
- Free space for a cycle = (4 - fifo_count) + pop. Pushes are accepted in slot order until free space runs out.
- Each rejected push sets overflow. Accepted pushes are still written.
- ovf_clr clears overflow. If a drop occurs in the same cycle as ovf_clr, the drop wins and overflow stays 1.
- Reset (asynchronous, mid-operation included): FIFO is emptied, pointers go to 0, FSM goes to IDLE, and hcnt, press_count, overflow, btn_prev and swt_prev clear to 0. All outputs read 0.

## Timing
- Input level change present before edge k: the FIFO is written at edge k. evt_valid and evt_code are valid after edge k. Latency is 1 cycle; there is no input synchronizer, because the inputs are already synchronous.
- PRESS at edge k, button held: LONG_HOLD is pushed at edge k+L.
- Release at edge k+j with j<L gives RELEASE_SHORT.
- Release at edge k+L itself gives RELEASE_SHORT with no LONG_HOLD (release has priority).
- evt_code, evt_valid and fifo_count are registered-state decodes: no combinational path from evt_ack or the inputs to them.
- Pop at edge k: the next entry appears after edge k.
- Push and pop at edge k when full: both succeed, fifo_count stays 4, no overflow.
- Push and pop at edge k when empty: the new entry is visible after edge k, and evt_valid rises.
- press_count updates on the same edge as the PRESS push, even if that push is dropped.

## Test plan
- Reset with BTN_in=SWT_in=0, then raise SWT_in. Required: SWT_ON (5) after 1 cycle, fifo_count=1; evt_ack gives fifo_count=0, evt_valid=0, evt_code=0.
- SIMULATE=1: press for 4 cycles, then release. Required: queue holds 1, 2; press_count=1; btn_state returns to 0.
- SIMULATE=1: press for 15 cycles. Required: LONG_HOLD exactly 10 cycles after PRESS, btn_state=2, then release gives RELEASE_LONG. Queue holds 1, 4, 3.
- SIMULATE=1: release on exactly cycle 10. Required: queue holds 1, 2 only.
- BTN_in and SWT_in rise on the same edge with fifo_count=3 and no ack. Required: PRESS stored, SWT_ON dropped, overflow=1, fifo_count=4. A subsequent ovf_clr gives overflow=0.
- Full FIFO with evt_ack and a new event on the same edge. Required: fifo_count stays 4, overflow stays 0, order preserved.
- Assert reset mid-HELD with 3 queued entries. Required: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/enc_btn_event_queue.sv
// Turns debounced PmodENC button/switch levels into press/release/hold/switch
// events and queues them in a 4-deep FIFO drained through a valid/ack handshake.
module enc_btn_event_queue #(
    parameter int unsigned CLOCK_FREQ_HZ = 100000000,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned SIMULATE      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BTN_in,
    input  logic        SWT_in,
    input  logic        evt_ack,
    input  logic        ovf_clr,
    output logic        evt_valid,
    output logic [2:0]  evt_code,
    output logic [2:0]  fifo_count,
    output logic        overflow,
    output logic [15:0] press_count,
    output logic [1:0]  btn_state
);

    localparam logic [31:0] L      = (SIMULATE != 0) ? 32'd10
                                   : 32'((CLOCK_FREQ_HZ / 1000) * LONG_PRESS_MS);
    localparam logic [31:0] L_LAST = L - 32'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_fsm_t;

    typedef enum logic [2:0] {
        EV_NONE          = 3'd0,
        EV_PRESS         = 3'd1,
        EV_RELEASE_SHORT = 3'd2,
        EV_RELEASE_LONG  = 3'd3,
        EV_LONG_HOLD     = 3'd4,
        EV_SWT_ON        = 3'd5,
        EV_SWT_OFF       = 3'd6
    } evt_t;

    btn_fsm_t    state, state_nxt;
    logic [31:0] hcnt;
    logic        hcnt_clr, hcnt_inc;
    logic        btn_prev, swt_prev;
    logic        btn_rise;
    evt_t        btn_evt, swt_evt;

    evt_t        mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        pop;
    logic [2:0]  free;
    logic        req0, req1;
    evt_t        slot0, slot1;
    logic [1:0]  n_req, n_acc;
    logic        acc0, acc1, drop;

    assign btn_rise = BTN_in & ~btn_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_rise) state_nxt = PRESSED;
            PRESSED: begin
                if (!BTN_in)              state_nxt = IDLE;
                else if (hcnt == L_LAST)  state_nxt = HELD;
            end
            HELD:    if (!BTN_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Release is tested before the hold threshold so a release on the
    // threshold edge reports a short release and never a long hold.
    always_comb begin
        btn_evt  = EV_NONE;
        hcnt_clr = 1'b0;
        hcnt_inc = 1'b0;
        case (state)
            IDLE: if (btn_rise) begin
                btn_evt  = EV_PRESS;
                hcnt_clr = 1'b1;
            end
            PRESSED: begin
                if (!BTN_in)             btn_evt = EV_RELEASE_SHORT;
                else if (hcnt == L_LAST) btn_evt = EV_LONG_HOLD;
                else                     hcnt_inc = 1'b1;
            end
            HELD:    if (!BTN_in) btn_evt = EV_RELEASE_LONG;
            default: btn_evt = EV_NONE;
        endcase
    end

    assign btn_state = state;

    always_comb begin
        swt_evt = EV_NONE;
        if (SWT_in && !swt_prev)      swt_evt = EV_SWT_ON;
        else if (!SWT_in && swt_prev) swt_evt = EV_SWT_OFF;
    end

    // Requests are packed so the button event always lands ahead of the switch event.
    always_comb begin
        pop   = evt_ack && (count != 3'd0);
        free  = 3'd4 - count + {2'b00, pop};
        req0  = (btn_evt != EV_NONE);
        req1  = (swt_evt != EV_NONE);
        slot0 = req0 ? btn_evt : swt_evt;
        slot1 = swt_evt;
        n_req = {1'b0, req0} + {1'b0, req1};
        acc0  = (n_req >= 2'd1) && (free >= 3'd1);
        acc1  = (n_req == 2'd2) && (free >= 3'd2);
        n_acc = {1'b0, acc0} + {1'b0, acc1};
        drop  = ((n_req >= 2'd1) && !acc0) || ((n_req == 2'd2) && !acc1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) mem[i] <= EV_NONE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (acc0) mem[wr_ptr] <= slot0;
            if (acc1) mem[wr_ptr + 2'd1] <= slot1;
            wr_ptr <= wr_ptr + n_acc;
            rd_ptr <= rd_ptr + {1'b0, pop};
            count  <= count - {2'b00, pop} + {1'b0, n_acc};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt        <= '0;
            press_count <= '0;
            overflow    <= 1'b0;
            btn_prev    <= 1'b0;
            swt_prev    <= 1'b0;
        end else begin
            btn_prev <= BTN_in;
            swt_prev <= SWT_in;
            if (hcnt_clr)      hcnt <= '0;
            else if (hcnt_inc) hcnt <= hcnt + 32'd1;
            if (btn_evt == EV_PRESS) press_count <= press_count + 16'd1;
            if (drop)          overflow <= 1'b1;
            else if (ovf_clr)  overflow <= 1'b0;
        end
    end

    assign evt_valid  = (count != 3'd0);
    assign evt_code   = (count != 3'd0) ? mem[rd_ptr] : 3'b000;
    assign fifo_count = count;

endmodule

// File: tb/tb_enc_btn_event_queue.sv
// Directed bench: stimulus pushes expected event codes into a scoreboard queue,
// a negedge monitor pops and compares every entry the bench acknowledges.
module tb_enc_btn_event_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        BTN_in, SWT_in, evt_ack, ovf_clr;
    logic        evt_valid;
    logic [2:0]  evt_code;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] press_count;
    logic [1:0]  btn_state;

    int          tests = 0;
    int          fails = 0;
    logic [2:0]  exp_q [$];

    enc_btn_event_queue #(
        .CLOCK_FREQ_HZ(100000000),
        .LONG_PRESS_MS(1000),
        .SIMULATE(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .BTN_in(BTN_in),
        .SWT_in(SWT_in),
        .evt_ack(evt_ack),
        .ovf_clr(ovf_clr),
        .evt_valid(evt_valid),
        .evt_code(evt_code),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .press_count(press_count),
        .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        evt_ack = 1'b1;
        repeat (n) tick();
        evt_ack = 1'b0;
    endtask

    // Monitor: every acknowledged head entry must match the scoreboard front.
    always @(negedge clk) begin
        if (reset && evt_ack && evt_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon_extra: got code %0d expected no entry", evt_code);
            end else begin
                chk("mon_code", {29'd0, evt_code}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        BTN_in = 0; SWT_in = 0; evt_ack = 0; ovf_clr = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_count", {29'd0, fifo_count}, 0);
        chk("rst_press", {16'd0, press_count}, 0);
        chk("rst_state", {30'd0, btn_state}, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Switch rising edge
        SWT_in = 1; exp_q.push_back(3'd5);
        tick();
        chk("swt_code", {29'd0, evt_code}, 5);
        chk("swt_count", {29'd0, fifo_count}, 1);
        drain(1);
        chk("pop_count", {29'd0, fifo_count}, 0);
        chk("pop_valid", {31'd0, evt_valid}, 0);
        chk("pop_code", {29'd0, evt_code}, 0);

        // Short press: 4 high cycles then release
        BTN_in = 1; exp_q.push_back(3'd1);
        tick();
        chk("short_state", {30'd0, btn_state}, 1);
        repeat (3) tick();
        BTN_in = 0; exp_q.push_back(3'd2);
        tick();
        chk("short_count", {29'd0, fifo_count}, 2);
        chk("short_press", {16'd0, press_count}, 1);
        chk("short_idle", {30'd0, btn_state}, 0);
        drain(2);

        // Long press: 15 high cycles
        BTN_in = 1; exp_q.push_back(3'd1);
        tick();
        repeat (9) tick();
        chk("long_pre", {29'd0, fifo_count}, 1);
        chk("long_pre_st", {30'd0, btn_state}, 1);
        exp_q.push_back(3'd4);
        tick();
        chk("long_hold_cnt", {29'd0, fifo_count}, 2);
        chk("long_held", {30'd0, btn_state}, 2);
        repeat (4) tick();
        BTN_in = 0; exp_q.push_back(3'd3);
        tick();
        chk("long_count", {29'd0, fifo_count}, 3);
        chk("long_idle", {30'd0, btn_state}, 0);
        chk("long_press", {16'd0, press_count}, 2);
        drain(3);

        // Release exactly on the threshold edge
        BTN_in = 1; exp_q.push_back(3'd1);
        tick();
        repeat (9) tick();
        BTN_in = 0; exp_q.push_back(3'd2);
        tick();
        repeat (3) tick();
        chk("thr_count", {29'd0, fifo_count}, 2);
        chk("thr_state", {30'd0, btn_state}, 0);
        drain(2);

        // Overflow: fill to 3, then button + switch on the same edge
        SWT_in = 0; exp_q.push_back(3'd6); tick();
        SWT_in = 1; exp_q.push_back(3'd5); tick();
        SWT_in = 0; exp_q.push_back(3'd6); tick();
        chk("fill3", {29'd0, fifo_count}, 3);
        BTN_in = 1; SWT_in = 1; exp_q.push_back(3'd1);
        tick();
        chk("ovf_count", {29'd0, fifo_count}, 4);
        chk("ovf_flag", {31'd0, overflow}, 1);
        chk("ovf_press", {16'd0, press_count}, 4);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_clr", {31'd0, overflow}, 0);

        // Full FIFO: pop and push on the same edge
        BTN_in = 0; evt_ack = 1; exp_q.push_back(3'd2);
        tick();
        evt_ack = 0;
        chk("full_count", {29'd0, fifo_count}, 4);
        chk("full_ovf", {31'd0, overflow}, 0);
        chk("full_head", {29'd0, evt_code}, 5);
        drain(4);
        chk("drained", {29'd0, fifo_count}, 0);

        // Asynchronous reset while HELD with 3 entries queued
        BTN_in = 1; exp_q.push_back(3'd1);
        tick();
        repeat (9) tick();
        exp_q.push_back(3'd4);
        tick();
        SWT_in = 0; exp_q.push_back(3'd6);
        tick();
        chk("pre_rst_count", {29'd0, fifo_count}, 3);
        chk("pre_rst_state", {30'd0, btn_state}, 2);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", {31'd0, evt_valid}, 0);
        chk("arst_code", {29'd0, evt_code}, 0);
        chk("arst_count", {29'd0, fifo_count}, 0);
        chk("arst_ovf", {31'd0, overflow}, 0);
        chk("arst_press", {16'd0, press_count}, 0);
        chk("arst_state", {30'd0, btn_state}, 0);
        BTN_in = 0;
        tick();
        reset = 1'b1;
        tick(); tick();
        chk("post_rst_count", {29'd0, fifo_count}, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
